// File: rtl/fwd_pkg.sv
// Shared types for the result forwarding pipe and forwarding mux.
// Entry layout: valid, destination register, result value.
package fwd_pkg;
  localparam int ADDR_W = 7;
  localparam int DATA_W = 128;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } fwd_entry_t;
endpackage

// File: rtl/result_fwd_pipe_sat_counter32.sv
// 32-bit saturating event counter, synchronous active-high reset.
// Used for insert/collision statistics under FWD_PIPE_STATS_EN.
module sat_counter32 (
  input  logic        clk,
  input  logic        reset,
  input  logic        inc,
  output logic [31:0] count
);
  always_ff @(posedge clk) begin
    if (reset)
      count <= '0;
    else if (inc && count != '1)
      count <= count + 32'd1;
  end
endmodule

// File: rtl/result_fwd_pipe.sv
// Per-pipe result delay line with per-stage forwarding taps and write-back.
// Optional statistics counters built when FWD_PIPE_STATS_EN is defined.
module result_fwd_pipe
  import fwd_pkg::*;
#(
  parameter int DEPTH      = 9,
  parameter int FLUSH_KEEP = 4,
  localparam int SW        = $clog2(DEPTH + 1)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  input  logic [SW-1:0]                 in_stage,
  input  logic [ADDR_W-1:0]             in_addr,
  input  logic [DATA_W-1:0]             in_data,
  input  logic                          flush,
  output logic [DEPTH-1:0]              tap_valid,
  output logic [DEPTH-1:0][ADDR_W-1:0]  tap_addr,
  output logic [DEPTH-1:0][DATA_W-1:0]  tap_data,
  output logic                          wb_valid,
  output logic [ADDR_W-1:0]             wb_addr,
  output logic [DATA_W-1:0]             wb_data,
  output logic                          collide,
  output logic                          bad_stage,
  output logic [31:0]                   stat_ins,
  output logic [31:0]                   stat_col
);
  localparam logic [SW-1:0] DEPTH_S = SW'(DEPTH);
  localparam logic [SW-1:0] KEEP_S  = SW'(FLUSH_KEEP);

  fwd_entry_t st  [DEPTH];
  fwd_entry_t nxt [DEPTH];

  logic ins_ok;
  logic ins_bad;
  logic ins_kill;
  logic col_hit;
  logic col_ev;

  assign ins_ok   = in_valid && in_stage != '0 && in_stage <= DEPTH_S;
  assign ins_bad  = in_valid && !ins_ok;
  assign ins_kill = flush && in_stage < KEEP_S;

  always_comb begin
    col_hit = 1'b0;
    nxt[0]  = '0;
    for (int i = 1; i < DEPTH; i++)
      nxt[i] = st[i-1];
    for (int i = 0; i < DEPTH; i++) begin
      if (ins_ok && in_stage == SW'(i + 1)) begin
        nxt[i] = '{valid: 1'b1, addr: in_addr, data: in_data};
        if (i > 0 && st[i-1].valid)
          col_hit = 1'b1;
      end
    end
    // Speculative stages are cleared after the shift and any insert.
    if (flush)
      for (int i = 0; i < FLUSH_KEEP - 1; i++)
        nxt[i] = '0;
  end

  // A discarded insert overwrites nothing that survives the flush.
  assign col_ev = col_hit && !ins_kill;

  always_ff @(posedge clk) begin
    if (reset) begin
      st        <= '{default: '0};
      collide   <= 1'b0;
      bad_stage <= 1'b0;
    end else begin
      st        <= nxt;
      collide   <= col_ev;
      bad_stage <= ins_bad;
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      tap_valid[i] = st[i].valid;
      tap_addr[i]  = st[i].addr;
      tap_data[i]  = st[i].data;
    end
  end

  assign wb_valid = st[DEPTH-1].valid;
  assign wb_addr  = st[DEPTH-1].addr;
  assign wb_data  = st[DEPTH-1].data;

`ifdef FWD_PIPE_STATS_EN
  sat_counter32 u_ins (
    .clk   (clk),
    .reset (reset),
    .inc   (ins_ok),
    .count (stat_ins)
  );

  sat_counter32 u_col (
    .clk   (clk),
    .reset (reset),
    .inc   (col_ev),
    .count (stat_col)
  );
`else
  assign stat_ins = '0;
  assign stat_col = '0;
`endif
endmodule
